// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 8-bit CPU; ALU ops plus register-file writeback.
// Optional iterative shift-add multiply is compiled in when EXEC_MUL_EN is defined.
module exec_unit #(
  parameter int DataBusWidth = 8,
  parameter int AddrBusWidth = 3
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    start,
  input  logic [3:0]              op,
  input  logic [DataBusWidth-1:0] opA,
  input  logic [DataBusWidth-1:0] opB,
  input  logic [AddrBusWidth-1:0] dest,
  output logic                    busy,
  output logic                    done,
  output logic [DataBusWidth-1:0] wbData,
  output logic [AddrBusWidth-1:0] wbAddr,
  output logic                    wbLoad,
  output logic                    flagZ,
  output logic                    flagC,
  output logic                    flagN
);
  localparam int W = DataBusWidth;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  logic [W:0]              sum_s;
  logic [W-1:0]            res_s;
  logic                    c_s;
  logic                    upd_s;
  logic                    wr_s;
  logic                    issue_s;
  logic                    mul_op_s;
  logic                    mul_fin_s;
  logic [2*W-1:0]          mul_res_s;
  logic [AddrBusWidth-1:0] mul_dest_s;

  logic [W-1:0]            data_r;
  logic [AddrBusWidth-1:0] addr_r;
  logic                    done_r;
  logic                    load_r;
  logic                    z_r;
  logic                    c_r;
  logic                    n_r;

  // Single-cycle ALU: result, carry and whether flags / register file get updated
  always_comb begin
    sum_s = '0;
    res_s = '0;
    c_s   = 1'b0;
    upd_s = 1'b1;
    wr_s  = 1'b1;
    case (op)
      OP_ADD: begin
        sum_s = {1'b0, opA} + {1'b0, opB};
        res_s = sum_s[W-1:0];
        c_s   = sum_s[W];
      end
      OP_SUB, OP_CMP: begin
        // borrow out of the extended subtraction is exactly A < B unsigned
        sum_s = {1'b0, opA} - {1'b0, opB};
        res_s = sum_s[W-1:0];
        c_s   = sum_s[W];
        if (op == OP_CMP) begin
          wr_s = 1'b0;
        end else begin
          wr_s = 1'b1;
        end
      end
      OP_AND: res_s = opA & opB;
      OP_OR:  res_s = opA | opB;
      OP_XOR: res_s = opA ^ opB;
      OP_NOT: res_s = ~opA;
      OP_SHL: begin
        res_s = opA << 1;
        c_s   = opA[W-1];
      end
      OP_SHR: begin
        res_s = opA >> 1;
        c_s   = opA[0];
      end
      OP_MOV: res_s = opB;
      default: begin
        upd_s = 1'b0;
        wr_s  = 1'b0;
      end
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [2*W-1:0]          acc_r;
  logic [2*W-1:0]          acc_nxt_s;
  logic [2*W-1:0]          mcand_r;
  logic [W-1:0]            mplier_r;
  logic [CW-1:0]           cnt_r;
  logic [AddrBusWidth-1:0] mdest_r;
  logic                    busy_r;

  assign mul_op_s   = (op == OP_MUL);
  assign issue_s    = start && (state_r == ST_IDLE);
  assign mul_fin_s  = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
  assign mul_res_s  = acc_nxt_s;
  assign mul_dest_s = mdest_r;
  assign busy       = busy_r;

  // Next-state logic: leave IDLE on a multiply issue, return after the last step
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && mul_op_s) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Multiplier state register and datapath
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      mdest_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (start && mul_op_s) begin
            mcand_r  <= {{W{1'b0}}, opA};
            mplier_r <= opB;
            acc_r    <= '0;
            cnt_r    <= '0;
            mdest_r  <= dest;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          busy_r   <= (cnt_r != CNT_LAST);
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end
`else
  assign mul_op_s   = 1'b0;
  assign issue_s    = start;
  assign mul_fin_s  = 1'b0;
  assign mul_res_s  = '0;
  assign mul_dest_s = '0;
  assign busy       = 1'b0;
`endif

  // Writeback port and status flags; done/wbLoad are single-cycle pulses
  always_ff @(posedge clk) begin
    if (!nRst) begin
      data_r <= '0;
      addr_r <= '0;
      done_r <= 1'b0;
      load_r <= 1'b0;
      z_r    <= 1'b0;
      c_r    <= 1'b0;
      n_r    <= 1'b0;
    end else if (mul_fin_s) begin
      done_r <= 1'b1;
      load_r <= 1'b1;
      data_r <= mul_res_s[W-1:0];
      addr_r <= mul_dest_s;
      z_r    <= (mul_res_s[W-1:0] == '0);
      n_r    <= mul_res_s[W-1];
      c_r    <= |mul_res_s[2*W-1:W];
    end else if (issue_s && !mul_op_s) begin
      done_r <= 1'b1;
      load_r <= wr_s;
      if (wr_s) begin
        data_r <= res_s;
        addr_r <= dest;
      end
      if (upd_s) begin
        z_r <= (res_s == '0);
        n_r <= res_s[W-1];
        c_r <= c_s;
      end
    end else begin
      done_r <= 1'b0;
      load_r <= 1'b0;
    end
  end

  assign done   = done_r;
  assign wbLoad = load_r;
  assign wbData = data_r;
  assign wbAddr = addr_r;
  assign flagZ  = z_r;
  assign flagC  = c_r;
  assign flagN  = n_r;
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, multi-cycle sequences,
// and randomized ops against an arithmetic reference model.
module tb_exec_unit;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          nRst;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic [AW-1:0] dest;
  logic          busy;
  logic          done;
  logic [W-1:0]  wbData;
  logic [AW-1:0] wbAddr;
  logic          wbLoad;
  logic          flagZ;
  logic          flagC;
  logic          flagN;

  int checks = 0;
  int errors = 0;

  // expected architectural state
  logic [W-1:0]  e_data;
  logic [AW-1:0] e_addr;
  logic          e_z, e_c, e_n;

  exec_unit #(.DataBusWidth(W), .AddrBusWidth(AW)) dut (
    .clk(clk), .nRst(nRst), .start(start), .op(op), .opA(opA), .opB(opB),
    .dest(dest), .busy(busy), .done(done), .wbData(wbData), .wbAddr(wbAddr),
    .wbLoad(wbLoad), .flagZ(flagZ), .flagC(flagC), .flagN(flagN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic c;
    logic upd;
    logic wr;
  } mres_t;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] d;
    logic [W-1:0]  xd;
    logic          xl;
    logic          xz;
    logic          xc;
    logic          xn;
  } vec_t;

  function automatic mres_t model(input int o, input int a, input int b);
    mres_t m;
    int t;
    m.c = 1'b0; m.upd = 1'b1; m.wr = 1'b1; t = 0;
    case (o)
      0: begin t = a + b; m.c = (t > 255); end
      1: begin t = a - b; m.c = (a < b); end
      10: begin t = a - b; m.c = (a < b); m.wr = 1'b0; end
      2: t = a & b;
      3: t = a | b;
      4: t = a ^ b;
      5: t = 255 - a;
      6: begin t = a * 2; m.c = (a >= 128); end
      7: begin t = a / 2; m.c = (a % 2 == 1); end
      8: t = b;
`ifdef EXEC_MUL_EN
      9: begin t = a * b; m.c = (t > 255); end
`endif
      default: begin m.upd = 1'b0; m.wr = 1'b0; end
    endcase
    t = t & 255;
    m.res = t[W-1:0];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic x_done, input logic x_load, input logic x_busy);
    chk({tag, " done"},   32'(done),   32'(x_done));
    chk({tag, " wbLoad"}, 32'(wbLoad), 32'(x_load));
    chk({tag, " busy"},   32'(busy),   32'(x_busy));
    chk({tag, " wbData"}, 32'(wbData), 32'(e_data));
    chk({tag, " flagZ"},  32'(flagZ),  32'(e_z));
    chk({tag, " flagC"},  32'(flagC),  32'(e_c));
    chk({tag, " flagN"},  32'(flagN),  32'(e_n));
    if (x_load) chk({tag, " wbAddr"}, 32'(wbAddr), 32'(e_addr));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    e_data = '0; e_addr = '0; e_z = 1'b0; e_c = 1'b0; e_n = 1'b0;
  endtask

  task automatic model_apply(input mres_t m, input logic [AW-1:0] d);
    if (m.upd) begin
      e_z = (m.res == '0);
      e_n = m.res[W-1];
      e_c = m.c;
    end
    if (m.wr) begin
      e_data = m.res;
      e_addr = d;
    end
  endtask

  vec_t tbl[14];

  initial begin
    mres_t m;
    bit    is_mul;
    tbl[0]  = '{4'd0,  8'hF0, 8'h20, 3'd3, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'd1,  8'h05, 8'h05, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'd10, 8'h03, 8'h04, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{4'd6,  8'h81, 8'h00, 3'd4, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'd7,  8'h81, 8'h00, 3'd5, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'd12, 8'hAA, 8'h55, 3'd6, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'd2,  8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{4'd3,  8'h80, 8'h01, 3'd1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{4'd4,  8'hFF, 8'hFF, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'd5,  8'h7F, 8'h00, 3'd3, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{4'd8,  8'h00, 8'h55, 3'd4, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'd0,  8'hFF, 8'h01, 3'd5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{4'd15, 8'h12, 8'h34, 3'd7, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{4'd1,  8'h00, 8'h01, 3'd6, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset with a start request pending: everything stays zero
    nRst = 1'b0; start = 1'b1; op = 4'd0; opA = 8'hF0; opB = 8'h20; dest = 3'd3;
    model_reset();
    cyc(); cyc();
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    chk("reset wbAddr", 32'(wbAddr), 32'd0);
    nRst = 1'b1; start = 1'b0;
    cyc();
    chk_all("post-reset idle", 1'b0, 1'b0, 1'b0);

    // directed table, issued back to back
    for (int i = 0; i < 14; i++) begin
      op = tbl[i].op; opA = tbl[i].a; opB = tbl[i].b; dest = tbl[i].d; start = 1'b1;
      cyc();
      e_data = tbl[i].xd; e_z = tbl[i].xz; e_c = tbl[i].xc; e_n = tbl[i].xn;
      if (tbl[i].xl) e_addr = tbl[i].d;
      chk_all($sformatf("vec%0d", i), 1'b1, tbl[i].xl, 1'b0);
    end
    start = 1'b0;
    cyc();
    chk_all("idle after table", 1'b0, 1'b0, 1'b0);

`ifdef EXEC_MUL_EN
    // multiply with a start attempt mid-operation
    op = 4'd9; opA = 8'h12; opB = 8'h10; dest = 3'd7; start = 1'b1;
    cyc();
    for (int j = 0; j < W; j++) begin
      start = (j == 2);
      op = 4'd0; opA = 8'h01; opB = 8'h01; dest = 3'd1;
      chk_all($sformatf("mul busy%0d", j), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    start = 1'b0;
    e_data = 8'h20; e_addr = 3'd7; e_z = 1'b0; e_c = 1'b1; e_n = 1'b0;
    chk_all("mul result", 1'b1, 1'b1, 1'b0);
    cyc();
    chk_all("mul idle", 1'b0, 1'b0, 1'b0);

    // reset four cycles into a multiply aborts it
    op = 4'd9; opA = 8'hFF; opB = 8'hFF; dest = 3'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    nRst = 1'b0;
    cyc();
    model_reset();
    chk_all("mul abort", 1'b0, 1'b0, 1'b0);
    nRst = 1'b1;
    for (int j = 0; j < W + 2; j++) begin
      cyc();
      chk_all($sformatf("abort quiet%0d", j), 1'b0, 1'b0, 1'b0);
    end
`else
    // op 9 is illegal without the multiplier
    op = 4'd9; opA = 8'h12; opB = 8'h10; dest = 3'd7; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("op9 illegal", 1'b1, 1'b0, 1'b0);
    cyc();
    chk_all("op9 idle", 1'b0, 1'b0, 1'b0);
`endif

    // randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        start = 1'b0; op = 4'($urandom_range(0, 15));
        opA = 8'($urandom); opB = 8'($urandom); dest = 3'($urandom);
        cyc();
        chk_all("rand gap", 1'b0, 1'b0, 1'b0);
      end else begin
        op = 4'($urandom_range(0, 15));
        opA = 8'($urandom); opB = 8'($urandom); dest = 3'($urandom);
        m = model(int'(op), int'(opA), int'(opB));
`ifdef EXEC_MUL_EN
        is_mul = (op == 4'd9);
`else
        is_mul = 1'b0;
`endif
        model_apply(m, dest);
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (is_mul) begin
          for (int j = 0; j < W; j++) begin
            opA = 8'($urandom); opB = 8'($urandom); dest = 3'($urandom);
            chk("rand mul busy", 32'(busy), 32'd1);
            chk("rand mul done", 32'(done), 32'd0);
            cyc();
          end
        end
        chk_all($sformatf("rand%0d op%0d", i, m.upd ? 1 : 0), 1'b1, m.wr, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
